// File: rtl/out_channel_checker.sv
// Streaming checker for the test machine's output channel: preload expected words,
// then compare each emitted word in order and report the outcome once the program finishes.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 100,
  parameter int CountWidth         = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expect_valid,
  input  logic [MemoryElementWidth-1:0] expect_data,
  output logic                          expect_ready,
  input  logic                          start,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          program_finished,
  output logic                          finished,
  output logic                          success,
  output logic [CountWidth-1:0]         received,
  output logic [CountWidth-1:0]         first_mismatch,
  output logic                          overflow
);

  typedef enum logic [1:0] {
    LOAD,
    CHECK,
    DONE
  } state_t;

  localparam logic [CountWidth-1:0] Capacity = CountWidth'(NOut);
  localparam logic [CountWidth-1:0] NoneIdx  = '1;

  state_t                        state;
  state_t                        state_next;
  logic [CountWidth-1:0]         nexp;
  logic [MemoryElementWidth-1:0] expect_mem [NOut];

  logic                  expect_hs;
  logic                  out_hs;
  logic                  in_range;
  logic [CountWidth-1:0] received_next;
  logic [CountWidth-1:0] first_mismatch_next;
  logic                  overflow_next;
  logic                  success_next;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, exactly as the flops do in hardware.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (start) state_next = CHECK;
      CHECK:   if (program_finished) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Handshake readiness depends only on registered state, never on *_valid.
  always_comb begin
    expect_ready = (state == LOAD) && (nexp < Capacity);
    out_ready    = (state == CHECK);
  end

  assign expect_hs = expect_valid && expect_ready;
  assign out_hs    = out_valid && out_ready;
  assign in_range  = (received < nexp);

  // NOTE: every variable gets a hold default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    received_next       = received;
    first_mismatch_next = first_mismatch;
    overflow_next       = overflow;
    if (out_hs) begin
      if (in_range && (out_data != expect_mem[received]) && (first_mismatch == NoneIdx))
        first_mismatch_next = received;
      if (!in_range)
        overflow_next = 1'b1;
      if (received != Capacity)
        received_next = received + 1'b1;
    end
    success_next = (first_mismatch_next == NoneIdx) && !overflow_next && (received_next == nexp);
  end

  // NOTE: the expected-word store has no reset; entries beyond nexp are never read,
  // so clearing it would only cost a reset fan-out into every memory bit.
  always_ff @(posedge clock) begin
    if (expect_hs) expect_mem[nexp] <= expect_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nexp           <= '0;
      received       <= '0;
      first_mismatch <= NoneIdx;
      overflow       <= 1'b0;
      finished       <= 1'b0;
      success        <= 1'b0;
    end else begin
      if (expect_hs) nexp <= nexp + 1'b1;
      received       <= received_next;
      first_mismatch <= first_mismatch_next;
      overflow       <= overflow_next;
      // Verdict is latched once, using the final handshake's results from this same cycle.
      if (state == CHECK && program_finished) begin
        finished <= 1'b1;
        success  <= success_next;
      end
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Self-checking bench for out_channel_checker: directed scenarios from the test plan plus
// randomized load/emit sequences scored against a sequence-level reference model.
module tb_out_channel_checker;

  localparam int W  = 12;
  localparam int NO = 100;
  localparam int CW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          expect_valid = 1'b0;
  logic [W-1:0]  expect_data = '0;
  logic          expect_ready;
  logic          start = 1'b0;
  logic          out_valid = 1'b0;
  logic [W-1:0]  out_data = '0;
  logic          out_ready;
  logic          program_finished = 1'b0;
  logic          finished;
  logic          success;
  logic [CW-1:0] received;
  logic [CW-1:0] first_mismatch;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NOut(NO),
    .CountWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .expect_valid(expect_valid),
    .expect_data(expect_data),
    .expect_ready(expect_ready),
    .start(start),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .program_finished(program_finished),
    .finished(finished),
    .success(success),
    .received(received),
    .first_mismatch(first_mismatch),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    expect_valid = 1'b0;
    start = 1'b0;
    out_valid = 1'b0;
    program_finished = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Drives a full load/start/emit/finish sequence and scores the verdict against
  // a model computed directly from the two word sequences.
  task automatic run_scenario(input logic [W-1:0] exp_q[$], input logic [W-1:0] sent_q[$],
                              input bit start_with_last, input bit finish_with_last,
                              input string name);
    int n_e = exp_q.size();
    int n_s = sent_q.size();
    int stored = (n_e > NO) ? NO : n_e;
    int m_rcv = (n_s > NO) ? NO : n_s;
    int m_fm = 127;
    bit m_ovf = (n_s > stored);
    bit m_succ;
    logic [CW-1:0] rcv_hold;
    for (int i = 0; i < n_s && i < stored; i++)
      if (sent_q[i] != exp_q[i] && m_fm == 127) m_fm = i;
    m_succ = (m_fm == 127) && !m_ovf && (m_rcv == stored);

    do_reset();
    n_checks++;
    if (out_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out_ready_in_load got=%0b exp=0", name, out_ready);
    end
    for (int i = 0; i < n_e; i++) begin
      expect_valid = 1'b1;
      expect_data = exp_q[i];
      if (start_with_last && i == n_e - 1) start = 1'b1;
      step();
    end
    expect_valid = 1'b0;
    if (!start_with_last || n_e == 0) begin
      start = 1'b1;
      step();
    end
    start = 1'b0;
    n_checks++;
    if (out_ready !== 1'b1 || expect_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_in_check got out=%0b exp_rdy=%0b exp=1/0", name, out_ready, expect_ready);
    end
    for (int i = 0; i < n_s; i++) begin
      out_valid = 1'b1;
      out_data = sent_q[i];
      if (finish_with_last && i == n_s - 1) program_finished = 1'b1;
      step();
    end
    out_valid = 1'b0;
    if (!finish_with_last || n_s == 0) begin
      program_finished = 1'b1;
      step();
    end
    program_finished = 1'b0;

    n_checks++;
    if (finished !== 1'b1) begin
      n_fail++;
      $display("FAIL %s finished got=%0b exp=1", name, finished);
    end
    n_checks++;
    if (success !== m_succ) begin
      n_fail++;
      $display("FAIL %s success got=%0b exp=%0b", name, success, m_succ);
    end
    n_checks++;
    if (received !== CW'(m_rcv)) begin
      n_fail++;
      $display("FAIL %s received got=%0d exp=%0d", name, received, m_rcv);
    end
    n_checks++;
    if (first_mismatch !== CW'(m_fm)) begin
      n_fail++;
      $display("FAIL %s first_mismatch got=%0d exp=%0d", name, first_mismatch, m_fm);
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL %s overflow got=%0b exp=%0b", name, overflow, m_ovf);
    end

    // DONE must ignore further control and data.
    rcv_hold = received;
    start = 1'b1;
    program_finished = 1'b1;
    out_valid = 1'b1;
    step();
    start = 1'b0;
    program_finished = 1'b0;
    out_valid = 1'b0;
    n_checks++;
    if (finished !== 1'b1 || received !== rcv_hold || out_ready !== 1'b0 || success !== m_succ) begin
      n_fail++;
      $display("FAIL %s done_hold got fin=%0b rcv=%0d rdy=%0b succ=%0b exp fin=1 rcv=%0d rdy=0 succ=%0b",
               name, finished, received, out_ready, success, rcv_hold, m_succ);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (finished !== 1'b0 || success !== 1'b0 || overflow !== 1'b0 || received !== '0 ||
        first_mismatch !== 7'h7f || expect_ready !== 1'b1 || out_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got fin=%0b succ=%0b ovf=%0b rcv=%0d fm=%0d erdy=%0b ordy=%0b exp 0 0 0 0 127 1 0",
               finished, success, overflow, received, first_mismatch, expect_ready, out_ready);
    end
    // program_finished in LOAD must be ignored.
    program_finished = 1'b1;
    step();
    program_finished = 1'b0;
    step();
    n_checks++;
    if (finished !== 1'b0 || expect_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL finish_in_load got fin=%0b erdy=%0b exp fin=0 erdy=1", finished, expect_ready);
    end
  endtask

  task automatic test_directed();
    run_scenario('{12'd2}, '{12'd2}, 1'b0, 1'b0, "basic_pass");
    run_scenario('{12'd2, 12'd5, 12'd7}, '{12'd2, 12'd6, 12'd7}, 1'b0, 1'b0, "mismatch_mid");
    run_scenario('{12'd2, 12'd5, 12'd7}, '{12'd2, 12'd6, 12'd8}, 1'b0, 1'b0, "mismatch_twice");
    run_scenario('{12'd2, 12'd5}, '{12'd2}, 1'b0, 1'b0, "short");
    run_scenario('{12'd2}, '{12'd2, 12'd3}, 1'b0, 1'b0, "overflow");
  endtask

  task automatic test_same_cycle();
    run_scenario('{12'd4, 12'd9}, '{12'd4, 12'd9}, 1'b1, 1'b0, "start_with_last");
    run_scenario('{12'd4, 12'd9}, '{12'd4, 12'd9}, 1'b0, 1'b1, "finish_with_last");
    run_scenario('{12'hfff}, '{12'hfff}, 1'b1, 1'b1, "all_ones_word");
    run_scenario('{12'hfff}, '{12'h7ff}, 1'b0, 1'b0, "msb_differs");
  endtask

  task automatic test_capacity();
    logic [W-1:0] words[$];
    do_reset();
    for (int i = 0; i < NO + 1; i++) begin
      n_checks++;
      if (expect_ready !== (i < NO)) begin
        n_fail++;
        $display("FAIL capacity_ready idx=%0d got=%0b exp=%0b", i, expect_ready, (i < NO));
      end
      expect_valid = 1'b1;
      expect_data = W'(i * 37);
      step();
    end
    expect_valid = 1'b0;
    for (int i = 0; i < NO + 1; i++) words.push_back(W'(i * 37));
    // 101 offered, 100 stored; sending 100 matches passes, sending 101 overflows.
    run_scenario(words, words[0:NO-1], 1'b0, 1'b0, "capacity_full");
    run_scenario(words, words, 1'b0, 1'b0, "capacity_overflow");
  endtask

  task automatic test_async_reset();
    do_reset();
    expect_valid = 1'b1;
    expect_data = 12'd2;
    step();
    expect_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    out_valid = 1'b1;
    out_data = 12'd3;
    step();
    out_valid = 1'b0;
    n_checks++;
    if (received !== 7'd1 || first_mismatch !== 7'd0) begin
      n_fail++;
      $display("FAIL pre_reset got rcv=%0d fm=%0d exp rcv=1 fm=0", received, first_mismatch);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (received !== '0 || first_mismatch !== 7'h7f || overflow !== 1'b0 || finished !== 1'b0 ||
        out_ready !== 1'b0 || expect_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got rcv=%0d fm=%0d ovf=%0b fin=%0b ordy=%0b erdy=%0b exp 0 127 0 0 0 1",
               received, first_mismatch, overflow, finished, out_ready, expect_ready);
    end
    step();
    reset = 1'b0;
    run_scenario('{12'd2}, '{12'd2}, 1'b0, 1'b0, "rerun_after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      logic [W-1:0] e[$];
      logic [W-1:0] s[$];
      int n_e = $urandom_range(1, 8);
      int mode = $urandom_range(0, 3);
      for (int i = 0; i < n_e; i++) e.push_back(W'($urandom_range(0, 15)));
      s = e;
      if (mode == 1) s[$urandom_range(0, n_e - 1)] = W'($urandom_range(0, 15));
      if (mode == 2) s.push_back(W'($urandom));
      if (mode == 3 && n_e > 1) void'(s.pop_back());
      run_scenario(e, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("random_%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_same_cycle();
    test_capacity();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
